// File: rtl/conv_symbol_encoder_pkg.sv
// Shared constants, FSM state type and the generator-polynomial encode helper
// for the rate-1/2 K=3 convolutional encoder.
package qam_pkg;

    localparam int CONV_K = 3;
    localparam logic [CONV_K-1:0] CONV_G0 = 3'o7;
    localparam logic [CONV_K-1:0] CONV_G1 = 3'o5;
    localparam int SYMBOLS_PER_FRAME = 32;

    typedef enum logic {
        S_DATA = 1'b0,
        S_TAIL = 1'b1
    } enc_state_t;

    // Tap vector is {current bit, newest past bit, oldest past bit}, MSB aligned
    // with the generator's leading coefficient.
    function automatic logic [1:0] conv_encode(input logic b, input logic [1:0] sr);
        logic [CONV_K-1:0] taps;
        taps = {b, sr[0], sr[1]};
        return {^(taps & CONV_G0), ^(taps & CONV_G1)};
    endfunction

endpackage

// File: rtl/conv_symbol_encoder_sym_fifo.sv
// First-word-fall-through FIFO of 2-bit symbols; the head is presented
// combinationally and reads as 00 while the FIFO is empty.
module sym_fifo #(
    parameter int DEPTH = 8
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         push,
    input  logic [1:0]                   din,
    input  logic                         pop,
    output logic [1:0]                   dout,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   level
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = $clog2(DEPTH+1);

    logic [1:0]       mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] level_q, level_d;
    logic             do_push;
    logic             do_pop;

    assign full    = (level_q == LVL_W'(DEPTH));
    assign empty   = (level_q == '0);
    assign level   = level_q;
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = empty ? 2'b00 : mem_q[rd_ptr_q];

    // DEPTH is a power of two, so the pointers wrap by plain overflow.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({do_push, do_pop})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Storage needs no reset: an entry is only ever read after being written.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

endmodule

// File: rtl/conv_symbol_encoder.sv
// Bit-serial rate-1/2 K=3 convolutional encoder with per-frame zero-tail
// termination, buffering {g0,g1} symbols for the QAM modulator.
module conv_symbol_encoder
    import qam_pkg::*;
#(
    parameter int FIFO_DEPTH = 8,
    parameter int FRAME_BITS = 30
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              enable,
    input  logic                              bit_in,
    input  logic                              bit_valid,
    output logic                              bit_ready,
    input  logic                              sym_take,
    output logic [1:0]                        conv_out,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_level,
    output logic                              frame_done,
    output logic                              underrun
);

    localparam int CNT_W     = $clog2(FRAME_BITS+1);
    localparam int TAIL_BITS = CONV_K - 1;

    enc_state_t       state_q, state_d;
    logic [1:0]       sr_q, sr_d;
    logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic             tail_cnt_q, tail_cnt_d;
    logic             underrun_q, underrun_d;
    logic             push;
    logic             enc_bit;
    logic [1:0]       push_sym;
    logic             fifo_full;
    logic             fifo_empty;

    // Full is judged before the edge, so a pop in the same cycle never frees
    // room for a push; tail bits are encoded as zeros through the same path.
    always_comb begin
        state_d    = state_q;
        sr_d       = sr_q;
        bit_cnt_d  = bit_cnt_q;
        tail_cnt_d = tail_cnt_q;
        push       = 1'b0;
        enc_bit    = 1'b0;
        bit_ready  = 1'b0;
        frame_done = 1'b0;
        case (state_q)
            S_DATA: begin
                bit_ready = enable && !fifo_full && !reset;
                if (bit_ready && bit_valid) begin
                    push    = 1'b1;
                    enc_bit = bit_in;
                    sr_d    = {sr_q[0], bit_in};
                    if (bit_cnt_q == CNT_W'(FRAME_BITS-1)) begin
                        bit_cnt_d  = '0;
                        tail_cnt_d = 1'b0;
                        state_d    = S_TAIL;
                    end else begin
                        bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    end
                end
            end
            S_TAIL: begin
                if (enable && !fifo_full) begin
                    push = 1'b1;
                    sr_d = {sr_q[0], 1'b0};
                    if (tail_cnt_q == 1'(TAIL_BITS-1)) begin
                        tail_cnt_d = 1'b0;
                        sr_d       = 2'b00;
                        frame_done = 1'b1;
                        state_d    = S_DATA;
                    end else begin
                        tail_cnt_d = tail_cnt_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = S_DATA;
            end
        endcase
    end

    assign push_sym   = conv_encode(enc_bit, sr_q);
    assign underrun_d = underrun_q || (sym_take && fifo_empty);
    assign underrun   = underrun_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_DATA;
            sr_q       <= 2'b00;
            bit_cnt_q  <= '0;
            tail_cnt_q <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            sr_q       <= sr_d;
            bit_cnt_q  <= bit_cnt_d;
            tail_cnt_q <= tail_cnt_d;
            underrun_q <= underrun_d;
        end
    end

    sym_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_sym_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .din   (push_sym),
        .pop   (sym_take),
        .dout  (conv_out),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fifo_level)
    );

endmodule

// File: tb/tb_conv_symbol_encoder.sv
// Scoreboard bench for conv_symbol_encoder: every accepted bit (and each frame's
// zero tail) queues its expected symbol, which is compared when popped.
module tb_conv_symbol_encoder;

    localparam int DEPTH = 8;
    localparam int FBITS = 30;

    logic       clk = 1'b0;
    logic       reset;
    logic       enable;
    logic       bit_in;
    logic       bit_valid;
    logic       bit_ready;
    logic       sym_take;
    logic [1:0] conv_out;
    logic [3:0] fifo_level;
    logic       frame_done;
    logic       underrun;

    int         checkCount = 0;
    int         passCount  = 0;
    logic [1:0] expQ [$];
    logic [1:0] mSr;
    int         mBits;
    int         acceptCount;
    int         popCount;
    int         frameDoneCount;
    int         lowCnt;

    conv_symbol_encoder #(
        .FIFO_DEPTH (DEPTH),
        .FRAME_BITS (FBITS)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .bit_in     (bit_in),
        .bit_valid  (bit_valid),
        .bit_ready  (bit_ready),
        .sym_take   (sym_take),
        .conv_out   (conv_out),
        .fifo_level (fifo_level),
        .frame_done (frame_done),
        .underrun   (underrun)
    );

    always #5 clk = ~clk;

    function automatic logic [1:0] modelEnc(input logic b, input logic [1:0] s);
        return {b ^ s[0] ^ s[1], b ^ s[1]};
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checkCount++;
        if (obs === exp) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clearModel();
        expQ.delete();
        mSr            = 2'b00;
        mBits          = 0;
        acceptCount    = 0;
        popCount       = 0;
        frameDoneCount = 0;
    endtask

    // Drive one cycle of inputs and return just after the following rising edge.
    task automatic applyStimulus(input logic b, input logic v, input logic t, input logic e);
        bit_in    = b;
        bit_valid = v;
        sym_take  = t;
        enable    = e;
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        reset     = 1'b1;
        bit_valid = 1'b0;
        sym_take  = 1'b0;
        enable    = 1'b0;
        bit_in    = 1'b0;
        clearModel();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 40; i++) begin
            if (fifo_level == 4'd0) break;
            applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
        end
        checkOutput("drainLevel", 32'(fifo_level), 32'd0);
        checkOutput("scoreboardLeft", 32'(expQ.size()), 32'd0);
    endtask

    // Model the encoder on the falling edge, mid-cycle, when inputs are stable.
    always @(negedge clk) begin
        logic [1:0] e;
        if (!reset) begin
            if (bit_valid && bit_ready) begin
                expQ.push_back(modelEnc(bit_in, mSr));
                mSr = {mSr[0], bit_in};
                mBits++;
                acceptCount++;
                if (mBits == FBITS) begin
                    expQ.push_back(modelEnc(1'b0, mSr));
                    mSr = {mSr[0], 1'b0};
                    expQ.push_back(modelEnc(1'b0, mSr));
                    mSr   = 2'b00;
                    mBits = 0;
                end
            end
            if (sym_take && fifo_level != 4'd0) begin
                popCount++;
                if (expQ.size() == 0) begin
                    checkOutput("scoreboardEmpty", 32'd1, 32'd0);
                end else begin
                    e = expQ.pop_front();
                    checkOutput("popSymbol", 32'(conv_out), 32'(e));
                end
            end
            if (frame_done) frameDoneCount++;
        end
    end

    initial begin
        reset     = 1'b1;
        enable    = 1'b0;
        bit_in    = 1'b0;
        bit_valid = 1'b0;
        sym_take  = 1'b0;
        clearModel();
        #2;
        checkOutput("rstReady", 32'(bit_ready), 32'd0);
        checkOutput("rstConvOut", 32'(conv_out), 32'd0);
        checkOutput("rstLevel", 32'(fifo_level), 32'd0);
        checkOutput("rstFrameDone", 32'(frame_done), 32'd0);
        checkOutput("rstUnderrun", 32'(underrun), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        // Encode 1,0,1,1 without popping
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b1);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b1);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b1);
        bit_valid = 1'b0;
        checkOutput("encLevel", 32'(fifo_level), 32'd4);
        checkOutput("encHead", 32'(conv_out), 32'h3);
        checkOutput("encAccepted", 32'(acceptCount), 32'd4);
        drain();

        // Underrun is sticky
        doReset();
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
        checkOutput("undFlag", 32'(underrun), 32'd1);
        checkOutput("undConvOut", 32'(conv_out), 32'd0);
        checkOutput("undLevel", 32'(fifo_level), 32'd0);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        checkOutput("undSticky", 32'(underrun), 32'd1);
        checkOutput("undLevelAfter", 32'(fifo_level), 32'd1);
        drain();

        // Full FIFO back-pressure
        doReset();
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'($urandom_range(0, 1)), 1'b1, 1'b0, 1'b1);
        end
        checkOutput("fullAccepted", 32'(acceptCount), 32'd8);
        checkOutput("fullReady", 32'(bit_ready), 32'd0);
        checkOutput("fullLevel", 32'(fifo_level), 32'd8);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b1);
        checkOutput("fullPopNoAccept", 32'(acceptCount), 32'd8);
        checkOutput("fullLevelAfterPop", 32'(fifo_level), 32'd7);
        checkOutput("fullReadyAfterPop", 32'(bit_ready), 32'd1);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b1);
        checkOutput("fullRefillAccepted", 32'(acceptCount), 32'd9);
        checkOutput("fullRefillLevel", 32'(fifo_level), 32'd8);
        checkOutput("fullRefillReady", 32'(bit_ready), 32'd0);
        drain();

        // Simultaneous push and pop
        doReset();
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b1);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b1);
        checkOutput("ppLevelBefore", 32'(fifo_level), 32'd3);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b1);
        checkOutput("ppLevelAfter", 32'(fifo_level), 32'd3);
        checkOutput("ppHead", 32'(conv_out), 32'h2);
        drain();

        // Full frame of ones followed by the zero tail
        doReset();
        for (int c = 0; c < 100; c++) begin
            if (acceptCount >= FBITS) break;
            applyStimulus(1'b1, 1'b1, fifo_level != 4'd0, 1'b1);
        end
        checkOutput("tailEntered", 32'(acceptCount), 32'(FBITS));
        lowCnt = 0;
        for (int c = 0; c < 10; c++) begin
            if (bit_ready) break;
            lowCnt++;
            applyStimulus(1'b0, 1'b0, fifo_level != 4'd0, 1'b1);
        end
        checkOutput("tailReadyLow", 32'(lowCnt), 32'd2);
        checkOutput("tailReadyBack", 32'(bit_ready), 32'd1);
        checkOutput("tailFrameDone", 32'(frameDoneCount), 32'd1);
        drain();
        checkOutput("tailSymbols", 32'(popCount), 32'd32);

        // Asynchronous reset in the middle of a frame
        doReset();
        for (int i = 0; i < 12; i++) begin
            applyStimulus(1'($urandom_range(0, 1)), 1'b1, fifo_level != 4'd0, 1'b1);
        end
        bit_in    = 1'b1;
        bit_valid = 1'b1;
        sym_take  = 1'b0;
        #2;
        reset = 1'b1;
        clearModel();
        #1;
        checkOutput("midRstReady", 32'(bit_ready), 32'd0);
        checkOutput("midRstConvOut", 32'(conv_out), 32'd0);
        checkOutput("midRstLevel", 32'(fifo_level), 32'd0);
        checkOutput("midRstUnderrun", 32'(underrun), 32'd0);
        bit_valid = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b1);
        bit_valid = 1'b0;
        checkOutput("midRstLevelAfter", 32'(fifo_level), 32'd2);
        checkOutput("midRstHead", 32'(conv_out), 32'h3);
        drain();

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
